mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Accepts one request at a time and registers it onto the memory interface.
- Tracks exactly one outstanding transaction and routes the response back to the requester that owns it.
- LS has fixed priority over IF, bounded by an IF anti-starvation counter.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the memory port arbiter.
// Directions in the names are from the arbiter's point of view.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i;
   logic        ls_we_i;
   logic [3:0]  ls_be_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic        ls_gnt_o;
   logic        ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one
// outstanding transaction; LS has priority, IF is protected by a starvation counter.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_gnt, ls_gnt, rsp;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         starve_cnt_q <= 4'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'd0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_gnt       = 1'b0;
      ls_gnt       = 1'b0;
      rsp          = 1'b0;
      case (state_q)
         S_IDLE: begin
            // LS wins contention until IF has lost LIMIT arbitrations in a row
            if (bus.ls_req_i && (!bus.if_req_i || starve_cnt_q < LIMIT)) begin
               ls_gnt      = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.ls_we_i;
               mem_be_d    = bus.ls_be_i;
               mem_addr_d  = bus.ls_addr_i;
               mem_wdata_d = bus.ls_wdata_i;
               owner_d     = OWN_LS;
               state_d     = S_REQ;
               if (bus.if_req_i) starve_cnt_d = starve_cnt_q + 4'd1;
            end else if (bus.if_req_i) begin
               if_gnt       = 1'b1;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_be_d     = 4'hF;
               mem_addr_d   = bus.if_addr_i;
               mem_wdata_d  = 32'd0;
               owner_d      = OWN_IF;
               state_d      = S_REQ;
               starve_cnt_d = 4'd0;
            end
         end
         S_REQ: begin
            if (bus.mem_gnt_i) begin
               mem_req_d = 1'b0;
               if (bus.mem_rvalid_i) begin
                  rsp     = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.mem_rvalid_i) begin
               rsp     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Combinational outputs are forced low while reset is held
   assign bus.if_gnt_o    = if_gnt & ~rst_i;
   assign bus.ls_gnt_o    = ls_gnt & ~rst_i;
   assign bus.if_rvalid_o = rsp & (owner_q == OWN_IF) & ~rst_i;
   assign bus.ls_rvalid_o = rsp & (owner_q == OWN_LS) & ~rst_i;
   assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : 32'd0;
   assign bus.ls_rdata_o  = bus.ls_rvalid_o ? bus.mem_rdata_i : 32'd0;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expected grants,
// memory requests and responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct packed {
      logic        ls;
      logic [31:0] data;
   } rsp_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic        auto_mode = 1'b0;
   logic        man_gnt = 1'b0;
   logic        man_rvalid = 1'b0;
   logic [31:0] man_rdata = 32'd0;

   int vectors = 0;
   int errors  = 0;

   logic     exp_gnt[$];
   mem_exp_t exp_mem[$];
   rsp_exp_t exp_rsp[$];

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Auto mode: memory grants and answers in the same cycle as the request
   assign bus.mem_gnt_i    = auto_mode ? bus.mem_req_o : man_gnt;
   assign bus.mem_rvalid_i = auto_mode ? bus.mem_req_o : man_rvalid;
   assign bus.mem_rdata_i  = auto_mode ? (bus.mem_addr_o ^ 32'hA5A5_0000) : man_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = 32'd0;
      bus.ls_req_i   = 1'b0;
      bus.ls_we_i    = 1'b0;
      bus.ls_be_i    = 4'd0;
      bus.ls_addr_i  = 32'd0;
      bus.ls_wdata_i = 32'd0;
      man_gnt        = 1'b0;
      man_rvalid     = 1'b0;
      man_rdata      = 32'd0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"},  {31'd0, bus.if_gnt_o}, 32'd0);
      chk({tag, "_ls_gnt"},  {31'd0, bus.ls_gnt_o}, 32'd0);
      chk({tag, "_if_rv"},   {31'd0, bus.if_rvalid_o}, 32'd0);
      chk({tag, "_ls_rv"},   {31'd0, bus.ls_rvalid_o}, 32'd0);
      chk({tag, "_if_rd"},   bus.if_rdata_o, 32'd0);
      chk({tag, "_ls_rd"},   bus.ls_rdata_o, 32'd0);
      chk({tag, "_mem_req"}, {31'd0, bus.mem_req_o}, 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
      chk({tag, "_mem_be"},  {28'd0, bus.mem_be_o}, 32'd0);
      chk({tag, "_busy"},    {31'd0, bus.busy_o}, 32'd0);
   endtask

   // Monitor: pops the scoreboards whenever the DUT presents a grant, accepted request or response
   always @(negedge clk) begin
      if (bus.if_gnt_o || bus.ls_gnt_o) begin
         chk("gnt_onehot", {31'd0, bus.if_gnt_o & bus.ls_gnt_o}, 32'd0);
         vectors++;
         if (exp_gnt.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected: got if=%b ls=%b expected none", bus.if_gnt_o, bus.ls_gnt_o);
         end else begin
            automatic logic e = exp_gnt.pop_front();
            chk("gnt_is_ls", {31'd0, bus.ls_gnt_o}, {31'd0, e});
         end
      end
      if (bus.mem_req_o && bus.mem_gnt_i) begin
         vectors++;
         if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: got addr=%h expected no request", bus.mem_addr_o);
         end else begin
            automatic mem_exp_t m = exp_mem.pop_front();
            chk("mem_we",    {31'd0, bus.mem_we_o}, {31'd0, m.we});
            chk("mem_be",    {28'd0, bus.mem_be_o}, {28'd0, m.be});
            chk("mem_addr",  bus.mem_addr_o, m.addr);
            chk("mem_wdata", bus.mem_wdata_o, m.wdata);
         end
      end
      if (bus.if_rvalid_o || bus.ls_rvalid_o) begin
         chk("rv_onehot", {31'd0, bus.if_rvalid_o & bus.ls_rvalid_o}, 32'd0);
         vectors++;
         if (exp_rsp.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got if_rv=%b ls_rv=%b expected none", bus.if_rvalid_o, bus.ls_rvalid_o);
         end else begin
            automatic rsp_exp_t r = exp_rsp.pop_front();
            chk("rsp_is_ls", {31'd0, bus.ls_rvalid_o}, {31'd0, r.ls});
            chk("rsp_data", r.ls ? bus.ls_rdata_o : bus.if_rdata_o, r.data);
            chk("rsp_other_data", r.ls ? bus.if_rdata_o : bus.ls_rdata_o, 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      bus.if_req_i = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk_all_zero("reset");
      cyc();
      bus.if_req_i = 1'b0;
      rst = 1'b0;
      cyc();

      // Single IF read with separate gnt and rvalid
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h100;
      exp_gnt.push_back(1'b0);
      exp_mem.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0});
      @(negedge clk);
      chk("t1_if_gnt_c0", {31'd0, bus.if_gnt_o}, 32'd1);
      cyc();
      bus.if_req_i = 1'b0;
      @(negedge clk);
      chk("t1_mem_req_c1", {31'd0, bus.mem_req_o}, 32'd1);
      chk("t1_mem_addr_c1", bus.mem_addr_o, 32'h100);
      chk("t1_mem_be_c1", {28'd0, bus.mem_be_o}, 32'hF);
      chk("t1_mem_we_c1", {31'd0, bus.mem_we_o}, 32'd0);
      cyc();
      man_gnt = 1'b1;
      cyc();
      man_gnt    = 1'b0;
      man_rvalid = 1'b1;
      man_rdata  = 32'hDEAD_BEEF;
      exp_rsp.push_back('{ls: 1'b0, data: 32'hDEAD_BEEF});
      @(negedge clk);
      chk("t1_mem_req_dropped", {31'd0, bus.mem_req_o}, 32'd0);
      chk("t1_busy_wait", {31'd0, bus.busy_o}, 32'd1);
      cyc();
      man_rvalid = 1'b0;
      man_rdata  = 32'd0;
      @(negedge clk);
      chk("t1_idle_c4", {31'd0, bus.busy_o}, 32'd0);
      cyc();

      // LS write, memory grants and acks in the same cycle
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b1;
      bus.ls_be_i    = 4'b0011;
      bus.ls_addr_i  = 32'h20;
      bus.ls_wdata_i = 32'h1234;
      exp_gnt.push_back(1'b1);
      exp_mem.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h20, wdata: 32'h1234});
      cyc();
      idle_inputs();
      man_gnt    = 1'b1;
      man_rvalid = 1'b1;
      man_rdata  = 32'hCAFE_0001;
      exp_rsp.push_back('{ls: 1'b1, data: 32'hCAFE_0001});
      @(negedge clk);
      chk("t2_ls_rv_in_gnt_cycle", {31'd0, bus.ls_rvalid_o}, 32'd1);
      cyc();
      idle_inputs();
      @(negedge clk);
      chk("t2_idle", {31'd0, bus.busy_o}, 32'd0);
      cyc();

      // Contention: expect 4 LS, 1 IF, 4 LS, 1 IF
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h200;
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b0;
      bus.ls_be_i    = 4'hF;
      bus.ls_addr_i  = 32'h300;
      bus.ls_wdata_i = 32'h55;
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 9) begin
            exp_gnt.push_back(1'b0);
            exp_mem.push_back('{we: 1'b0, be: 4'hF, addr: 32'h200, wdata: 32'h0});
            exp_rsp.push_back('{ls: 1'b0, data: 32'h200 ^ 32'hA5A5_0000});
         end else begin
            exp_gnt.push_back(1'b1);
            exp_mem.push_back('{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h55});
            exp_rsp.push_back('{ls: 1'b1, data: 32'h300 ^ 32'hA5A5_0000});
         end
      end
      auto_mode = 1'b1;
      for (int i = 0; i < 20; i++) cyc();
      idle_inputs();
      auto_mode = 1'b0;
      @(negedge clk);
      chk("t3_idle", {31'd0, bus.busy_o}, 32'd0);
      chk("t3_gnts_consumed", exp_gnt.size(), 32'd0);
      cyc();

      // Stalled memory: request held, no grant while busy
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h400;
      exp_gnt.push_back(1'b0);
      exp_mem.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'h0});
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_req", {31'd0, bus.mem_req_o}, 32'd1);
         chk("t4_stall_addr", bus.mem_addr_o, 32'h400);
         chk("t4_stall_be", {28'd0, bus.mem_be_o}, 32'hF);
         chk("t4_stall_no_gnt", {31'd0, bus.if_gnt_o | bus.ls_gnt_o}, 32'd0);
         cyc();
      end
      bus.if_req_i = 1'b0;
      man_gnt      = 1'b1;
      man_rvalid   = 1'b1;
      man_rdata    = 32'h0BAD_F00D;
      exp_rsp.push_back('{ls: 1'b0, data: 32'h0BAD_F00D});
      cyc();
      idle_inputs();

      // Stray rvalid in IDLE
      man_rvalid = 1'b1;
      man_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("t5_stray_if_rv", {31'd0, bus.if_rvalid_o}, 32'd0);
      chk("t5_stray_ls_rv", {31'd0, bus.ls_rvalid_o}, 32'd0);
      chk("t5_stray_busy", {31'd0, bus.busy_o}, 32'd0);
      cyc();
      idle_inputs();

      // Reset asserted during WAIT drops the transaction
      bus.ls_req_i  = 1'b1;
      bus.ls_be_i   = 4'hF;
      bus.ls_addr_i = 32'h40;
      exp_gnt.push_back(1'b1);
      exp_mem.push_back('{we: 1'b0, be: 4'hF, addr: 32'h40, wdata: 32'h0});
      cyc();
      idle_inputs();
      man_gnt = 1'b1;
      cyc();
      man_gnt = 1'b0;
      @(negedge clk);
      chk("t5_in_wait", {31'd0, bus.busy_o}, 32'd1);
      #2;
      rst          = 1'b1;
      bus.if_req_i = 1'b1;
      man_rvalid   = 1'b1;
      man_rdata    = 32'h77;
      #1;
      chk_all_zero("t5_async_rst");
      cyc();
      idle_inputs();
      rst = 1'b0;
      cyc();
      man_rvalid = 1'b1;
      man_rdata  = 32'h99;
      @(negedge clk);
      chk("t5_post_rst_if_rv", {31'd0, bus.if_rvalid_o}, 32'd0);
      chk("t5_post_rst_ls_rv", {31'd0, bus.ls_rvalid_o}, 32'd0);
      cyc();
      idle_inputs();
      @(negedge clk);
      #1;
      chk("end_gnt_queue", exp_gnt.size(), 32'd0);
      chk("end_mem_queue", exp_mem.size(), 32'd0);
      chk("end_rsp_queue", exp_rsp.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
